// File: rtl/inst_exec_sequencer_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer:
// FSM state encoding, trap causes and the opcodes the datapath can execute.
package inst_exec_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_TRAP
  } seq_state_t;

  typedef enum logic [1:0] {
    TC_NONE     = 2'd0,
    TC_ILLEGAL  = 2'd1,
    TC_FETCH_TO = 2'd2
  } trap_cause_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Only register-register and register-immediate ALU ops are executable.
  function automatic logic is_alu_opcode(input logic [31:0] instr);
    return (instr[6:0] == OPC_OP_IMM) || (instr[6:0] == OPC_OP);
  endfunction

endpackage

// File: rtl/inst_exec_sequencer_if.sv
// Instruction-memory fetch channel: req/addr from the core, ack/rdata back
// from memory. Address is held stable for as long as req is high.
interface inst_exec_sequencer_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [31:0]     rdata;

  modport master (output req, addr, input  ack, rdata);
  modport slave  (input  req, addr, output ack, rdata);
endinterface

// File: rtl/inst_exec_sequencer_fetch_timeout_ctr.sv
// Counts FETCH cycles spent waiting for imem_ack; expired flags the last
// permitted wait cycle so the sequencer can trap instead of waiting forever.
module fetch_timeout_ctr #(
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam int W = $clog2(FETCH_TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc)   cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == W'(FETCH_TIMEOUT - 1));

endmodule

// File: rtl/inst_exec_sequencer.sv
// Multi-cycle control FSM for the single-issue core: fetch, decode, execute,
// writeback, with traps on illegal opcodes and fetch timeouts. Owns the PC.
module inst_exec_sequencer
  import inst_exec_sequencer_pkg::*;
#(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_PC      = '0,
  parameter int              FETCH_TIMEOUT = 16,
  parameter int              CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt_req,
  inst_exec_sequencer_if.master imem,
  output logic [31:0]           instr_q,
  output logic                  rf_re,
  output logic                  alu_en,
  output logic                  rf_we,
  output logic                  busy,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  input  logic                  trap_clr,
  output logic [CNT_W-1:0]      retired
);

  seq_state_t      state;
  trap_cause_t     cause_q;
  logic [XLEN-1:0] pc;
  logic            req_q;
  logic            to_expired;
  logic            in_fetch;

  assign in_fetch   = (state == S_FETCH);
  assign imem.req   = req_q;
  assign imem.addr  = pc;
  assign trap_cause = cause_q;

  fetch_timeout_ctr #(.FETCH_TIMEOUT(FETCH_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_fetch || imem.ack),
    .inc     (in_fetch && !imem.ack && !to_expired),
    .expired (to_expired)
  );

  // Strobes are registered alongside the state so each one is a clean
  // single-cycle pulse aligned with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      instr_q <= '0;
      retired <= '0;
      cause_q <= TC_NONE;
      req_q   <= 1'b0;
      rf_re   <= 1'b0;
      alu_en  <= 1'b0;
      rf_we   <= 1'b0;
      busy    <= 1'b0;
      trap    <= 1'b0;
    end else begin
      // NOTE: every sequential assignment is non-blocking so all state bits
      // update together from the same pre-edge values.
      rf_re  <= 1'b0;
      alu_en <= 1'b0;
      rf_we  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            req_q <= 1'b1;
            busy  <= 1'b1;
          end
        end

        S_FETCH: begin
          if (imem.ack) begin
            instr_q <= imem.rdata;
            req_q   <= 1'b0;
            rf_re   <= is_alu_opcode(imem.rdata);
            state   <= S_DECODE;
          end else if (to_expired) begin
            req_q   <= 1'b0;
            busy    <= 1'b0;
            trap    <= 1'b1;
            cause_q <= TC_FETCH_TO;
            state   <= S_TRAP;
          end
        end

        S_DECODE: begin
          if (is_alu_opcode(instr_q)) begin
            alu_en <= 1'b1;
            state  <= S_EXECUTE;
          end else begin
            busy    <= 1'b0;
            trap    <= 1'b1;
            cause_q <= TC_ILLEGAL;
            state   <= S_TRAP;
          end
        end

        S_EXECUTE: begin
          rf_we <= (instr_q[11:7] != 5'd0);
          state <= S_WRITEBACK;
        end

        S_WRITEBACK: begin
          pc <= pc + XLEN'(4);
          if (retired != '1) retired <= retired + 1'b1;
          if (halt_req) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            req_q <= 1'b1;
            state <= S_FETCH;
          end
        end

        S_TRAP: begin
          // The PC is left on the faulting instruction for the handler.
          if (trap_clr) begin
            trap    <= 1'b0;
            cause_q <= TC_NONE;
            state   <= S_IDLE;
          end
        end

        default: begin
          req_q <= 1'b0;
          busy  <= 1'b0;
          trap  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_exec_sequencer.sv
// Directed bench for inst_exec_sequencer: a default DUT plus a second one with
// RESET_PC near the top of memory and a 2-bit retired counter.
module tb_inst_exec_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic        trap_clr;
  logic        ack;
  logic [31:0] rdata;

  logic [31:0] instr_q0, instr_q1;
  logic        rf_re0, rf_re1, alu_en0, alu_en1, rf_we0, rf_we1;
  logic        busy0, busy1, trap0, trap1;
  logic [1:0]  trap_cause0, trap_cause1;
  logic [15:0] retired0;
  logic [1:0]  retired1;

  int checks = 0;
  int errors = 0;

  inst_exec_sequencer_if #(.XLEN(32)) imem0 ();
  inst_exec_sequencer_if #(.XLEN(32)) imem1 ();

  assign imem0.ack   = ack;
  assign imem0.rdata = rdata;
  assign imem1.ack   = ack;
  assign imem1.rdata = rdata;

  inst_exec_sequencer dut0 (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .imem(imem0.master),
    .instr_q(instr_q0), .rf_re(rf_re0), .alu_en(alu_en0), .rf_we(rf_we0),
    .busy(busy0), .trap(trap0), .trap_cause(trap_cause0), .trap_clr(trap_clr),
    .retired(retired0)
  );

  inst_exec_sequencer #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .imem(imem1.master),
    .instr_q(instr_q1), .rf_re(rf_re1), .alu_en(alu_en1), .rf_we(rf_we1),
    .busy(busy1), .trap(trap1), .trap_cause(trap_cause1), .trap_clr(trap_clr),
    .retired(retired1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From IDLE: start, then ack in the first FETCH cycle; returns observing DECODE.
  task automatic issue(input logic [31:0] instr);
    start = 1'b1;
    tick();
    start = 1'b0;
    ack   = 1'b1;
    rdata = instr;
    tick();
    ack   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; trap_clr = 1'b0;
    ack = 1'b0; rdata = '0;
    #12;
    check("rst_req",     imem0.req, 0);
    check("rst_busy",    busy0, 0);
    check("rst_trap",    trap0, 0);
    check("rst_pc",      imem0.addr, 0);
    check("rst_pc_hi",   imem1.addr, 32'hFFFF_FFFC);
    check("rst_instr",   instr_q0, 0);
    check("rst_retired", retired0, 0);
    rst = 1'b0;

    // 1: immediate ack, addi x1,x0,5 (plus wrap on dut1)
    halt_req = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("s1_fetch_req",  imem0.req, 1);
    check("s1_fetch_addr", imem0.addr, 0);
    check("s1_fetch_busy", busy0, 1);
    ack = 1'b1; rdata = 32'h0050_0093;
    tick();
    ack = 1'b0;
    check("s1_rf_re",   rf_re0, 1);
    check("s1_instr_q", instr_q0, 32'h0050_0093);
    check("s1_req_off", imem0.req, 0);
    tick();
    check("s1_alu_en",  alu_en0, 1);
    check("s1_rf_re_0", rf_re0, 0);
    tick();
    check("s1_rf_we",   rf_we0, 1);
    tick();
    check("s1_rf_we_0", rf_we0, 0);
    check("s1_idle",    busy0, 0);
    check("s1_pc",      imem0.addr, 4);
    check("s1_retired", retired0, 1);
    check("s6_pc_wrap", imem1.addr, 0);
    check("s6_retired", retired1, 1);

    // 2: ack delayed 3 cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("s2_req",  imem0.req, 1);
      check("s2_addr", imem0.addr, 4);
      if (i < 3) tick();
    end
    ack = 1'b1; rdata = 32'h00A0_0113;
    tick();
    ack = 1'b0;
    check("s2_rf_re", rf_re0, 1);
    tick();
    tick();
    check("s2_rf_we", rf_we0, 1);
    tick();
    check("s2_pc",      imem0.addr, 8);
    check("s2_retired", retired0, 2);

    // 3: addi x0 -> no register write
    issue(32'h0000_0013);
    check("s3_rf_re", rf_re0, 1);
    tick();
    tick();
    check("s3_rf_we", rf_we0, 0);
    tick();
    check("s3_pc",       imem0.addr, 12);
    check("s3_retired",  retired0, 3);
    check("s3_sat_hi",   retired1, 3);

    // 4: jal -> illegal-opcode trap, trap_clr wins over start
    issue(32'h0000_006F);
    check("s4_rf_re", rf_re0, 0);
    tick();
    check("s4_trap",   trap0, 1);
    check("s4_cause",  trap_cause0, 1);
    check("s4_busy",   busy0, 0);
    check("s4_alu_en", alu_en0, 0);
    check("s4_pc",     imem0.addr, 12);
    trap_clr = 1'b1; start = 1'b1;
    tick();
    trap_clr = 1'b0; start = 1'b0;
    check("s4_clr_trap",  trap0, 0);
    check("s4_clr_cause", trap_cause0, 0);
    check("s4_clr_req",   imem0.req, 0);
    tick();
    check("s4_stay_idle", busy0, 0);

    // 5: no ack -> fetch timeout after 16 cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (imem0.req && n < 40) begin
      n++;
      tick();
    end
    check("s5_req_cycles", n, 16);
    check("s5_trap",  trap0, 1);
    check("s5_cause", trap_cause0, 2);
    check("s5_req",   imem0.req, 0);
    check("s5_pc",    imem0.addr, 12);
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    check("s5_clr", trap0, 0);

    // 7: back-to-back, halt_req raised in EXECUTE of the second instruction
    halt_req = 1'b0;
    issue(32'h0010_0093);
    tick();
    tick();
    tick();
    check("s7_refetch_req",  imem0.req, 1);
    check("s7_refetch_addr", imem0.addr, 16);
    ack = 1'b1; rdata = 32'h0020_0113;
    tick();
    ack = 1'b0;
    tick();
    halt_req = 1'b1;
    tick();
    check("s7_rf_we", rf_we0, 1);
    tick();
    check("s7_idle",    busy0, 0);
    check("s7_req",     imem0.req, 0);
    check("s7_pc",      imem0.addr, 20);
    check("s7_retired", retired0, 5);
    check("s7_sat",     retired1, 3);

    // 8: async reset mid-fetch, late ack ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s8_req_pre", imem0.req, 1);
    #1 rst = 1'b1;
    #1;
    check("s8_req",     imem0.req, 0);
    check("s8_busy",    busy0, 0);
    check("s8_pc",      imem0.addr, 0);
    check("s8_retired", retired0, 0);
    check("s8_instr",   instr_q0, 0);
    ack = 1'b1; rdata = 32'h0000_0013;
    #1 rst = 1'b0;
    tick();
    ack = 1'b0;
    check("s8_late_ack_req",   imem0.req, 0);
    check("s8_late_ack_instr", instr_q0, 0);
    check("s8_late_ack_busy",  busy0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
